// File: rtl/rover_motion_pkg.sv
// Shared motion codes, requester indices and arbiter state encoding.
// Code-validity helpers used by the H-bridge arbiter.
package rover_motion_pkg;

    localparam logic [3:0] INERTIAL_STOP = 4'b0000;
    localparam logic [3:0] HARD_STOP     = 4'b1111;
    localparam logic [3:0] REVERSE       = 4'b0110;
    localparam logic [3:0] FORWARD       = 4'b1001;
    localparam logic [3:0] TURN_RIGHT    = 4'b0101;
    localparam logic [3:0] TURN_LEFT     = 4'b1010;

    localparam int REQ_STOP = 0;
    localparam int REQ_TURN = 1;
    localparam int REQ_LINE = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] BRAKE = 2'd2;

    function automatic logic is_drive_code(input logic [3:0] c);
        return (c == REVERSE) || (c == FORWARD) ||
               (c == TURN_RIGHT) || (c == TURN_LEFT);
    endfunction

    function automatic logic is_legal_code(input logic [3:0] c);
        return is_drive_code(c) || (c == INERTIAL_STOP) ||
               (c == HARD_STOP);
    endfunction

endpackage

// File: rtl/h_bridge_arbiter_if.sv
// Requester-side and bridge-side signals of the H-bridge arbiter.
// master: motion requesters / pin consumer; slave: the arbiter.
interface h_bridge_arbiter_if;
    logic [2:0] req;
    logic [3:0] cmd_stop;
    logic [3:0] cmd_turn;
    logic [3:0] cmd_line;
    logic [2:0] grant;
    logic [3:0] sendToH_BridgeINs;
    logic [1:0] enables_out;
    logic       braking;
    logic       illegal_cmd;

    modport master (
        output req, cmd_stop, cmd_turn, cmd_line,
        input  grant, sendToH_BridgeINs, enables_out,
        input  braking, illegal_cmd
    );

    modport slave (
        input  req, cmd_stop, cmd_turn, cmd_line,
        output grant, sendToH_BridgeINs, enables_out,
        output braking, illegal_cmd
    );
endinterface

// File: rtl/brake_timer.sv
// Loadable down-counter timing the HARD_STOP brake interval.
// done flags the cycle in which the count reaches zero.
module brake_timer #(
    parameter int N = 50000,
    localparam int W = $clog2(N + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= W'(N);
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = en && (cnt == W'(1));
endmodule

// File: rtl/h_bridge_arbiter.sv
// Fixed-priority owner of the H-bridge with braked polarity reversal.
// Optional enable PWM built when PWM_EN is defined.
module h_bridge_arbiter
    import rover_motion_pkg::*;
#(
    parameter int BRAKE_CYCLES = 50000,
    parameter int PWM_PERIOD   = 1000,
    parameter int PWM_DUTY     = 700
) (
    input logic clock,
    input logic reset,
    h_bridge_arbiter_if.slave bus
);
    logic [1:0] state, nxt_state;
    logic [3:0] ins_q, nxt_ins;
    logic [2:0] grant_q, nxt_grant;
    logic [1:0] en_q, nxt_en;
    logic       brk_q, nxt_brk;
    logic       ill_q, nxt_ill;
    logic [3:0] win_raw, win_code;
    logic [2:0] win_grant;
    logic [1:0] drive_en;
    logic       any_req, opposing, brk_load, brk_done;

`ifdef PWM_EN
    localparam int PW = $clog2(PWM_PERIOD + 1);
    logic [PW-1:0] pwm_cnt;

    always_ff @(posedge clock) begin
        if (reset || pwm_cnt == PW'(PWM_PERIOD - 1))
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + PW'(1);
    end

    assign drive_en = {2{pwm_cnt < PW'(PWM_DUTY)}};
`else
    logic unused_pwm;
    assign unused_pwm = ^{32'(PWM_PERIOD), 32'(PWM_DUTY)};
    assign drive_en   = 2'b11;
`endif

    always_comb begin
        win_grant = 3'b000;
        win_raw   = INERTIAL_STOP;
        if (bus.req[REQ_STOP]) begin
            win_grant = 3'b001;
            win_raw   = bus.cmd_stop;
        end else if (bus.req[REQ_TURN]) begin
            win_grant = 3'b010;
            win_raw   = bus.cmd_turn;
        end else if (bus.req[REQ_LINE]) begin
            win_grant = 3'b100;
            win_raw   = bus.cmd_line;
        end
    end

    assign any_req  = |bus.req;
    assign win_code = is_legal_code(win_raw) ? win_raw : HARD_STOP;
    assign opposing = is_drive_code(ins_q) && is_drive_code(win_code) &&
                      (ins_q != win_code);

    brake_timer #(.N(BRAKE_CYCLES)) u_brake (
        .clock (clock),
        .reset (reset),
        .load  (brk_load),
        .en    (state == BRAKE),
        .done  (brk_done)
    );

    // Default next outputs are "drive the winner"; branches override.
    always_comb begin
        nxt_state = DRIVE;
        nxt_ins   = win_code;
        nxt_grant = win_grant;
        nxt_en    = drive_en;
        nxt_brk   = 1'b0;
        nxt_ill   = any_req && !is_legal_code(win_raw);
        brk_load  = 1'b0;
        unique case (state)
            DRIVE: begin
                if (opposing) begin
                    nxt_state = BRAKE;
                    brk_load  = 1'b1;
                end
            end
            BRAKE: begin
                if (is_drive_code(win_code) && !brk_done)
                    nxt_state = BRAKE;
            end
            default: nxt_state = DRIVE;
        endcase
        if (!any_req) begin
            nxt_state = IDLE;
            nxt_ins   = INERTIAL_STOP;
            nxt_grant = 3'b000;
            nxt_en    = 2'b00;
            brk_load  = 1'b0;
        end else if (nxt_state == BRAKE) begin
            nxt_ins   = HARD_STOP;
            nxt_grant = 3'b000;
            nxt_en    = 2'b11;
            nxt_brk   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ins_q   <= INERTIAL_STOP;
            grant_q <= 3'b000;
            en_q    <= 2'b00;
            brk_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state   <= nxt_state;
            ins_q   <= nxt_ins;
            grant_q <= nxt_grant;
            en_q    <= nxt_en;
            brk_q   <= nxt_brk;
            ill_q   <= nxt_ill;
        end
    end

    assign bus.grant             = grant_q;
    assign bus.sendToH_BridgeINs = ins_q;
    assign bus.enables_out       = en_q;
    assign bus.braking           = brk_q;
    assign bus.illegal_cmd       = ill_q;
endmodule

// File: tb/tb_h_bridge_arbiter.sv
// Directed-vector bench for h_bridge_arbiter (default build, no PWM_EN).
// Observed vector is {grant, INs, enables, braking, illegal_cmd}.
module tb_h_bridge_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    h_bridge_arbiter_if bus ();

    h_bridge_arbiter #(
        .BRAKE_CYCLES (4),
        .PWM_PERIOD   (10),
        .PWM_DUTY     (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [10:0] obs;
    assign obs = {bus.grant, bus.sendToH_BridgeINs, bus.enables_out,
                  bus.braking, bus.illegal_cmd};

    function automatic logic [10:0] ev(input logic [2:0] g,
                                       input logic [3:0] c,
                                       input logic [1:0] en,
                                       input logic b,
                                       input logic i);
        return {g, c, en, b, i};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] e);
        n_vec++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b", tag, obs, e);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.req      = 3'b000;
        bus.cmd_stop = 4'b0000;
        bus.cmd_turn = 4'b0000;
        bus.cmd_line = 4'b0000;
        step();
        step();
        chk("reset", ev(3'b000, 4'b0000, 2'b00, 1'b0, 1'b0));
        reset = 1'b0;
        step();
        chk("idle", ev(3'b000, 4'b0000, 2'b00, 1'b0, 1'b0));

        // line follower forward
        bus.req = 3'b100; bus.cmd_line = 4'b1001;
        step(); chk("line_fwd", ev(3'b100, 4'b1001, 2'b11, 1'b0, 1'b0));
        step(); chk("line_hold", ev(3'b100, 4'b1001, 2'b11, 1'b0, 1'b0));

        // turn preempts with opposing code: 4 brake cycles
        bus.req = 3'b110; bus.cmd_turn = 4'b0101;
        step(); chk("brk1", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("brk2", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("brk3", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("brk4", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("brk_end", ev(3'b010, 4'b0101, 2'b11, 1'b0, 1'b0));

        // brake aborted by obstacle hard stop
        bus.cmd_turn = 4'b1010;
        step(); chk("abort_b1", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("abort_b2", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        bus.req = 3'b011; bus.cmd_stop = 4'b1111;
        step(); chk("abort", ev(3'b001, 4'b1111, 2'b11, 1'b0, 1'b0));

        // from HARD_STOP to a drive code is not opposing
        bus.req = 3'b100; bus.cmd_line = 4'b1001;
        step(); chk("stop_to_fwd", ev(3'b100, 4'b1001, 2'b11, 1'b0, 1'b0));
        bus.req = 3'b000;
        step(); chk("drop_idle", ev(3'b000, 4'b0000, 2'b00, 1'b0, 1'b0));
        step(); chk("stay_idle", ev(3'b000, 4'b0000, 2'b00, 1'b0, 1'b0));

        // illegal code
        bus.req = 3'b010; bus.cmd_turn = 4'b0011;
        step(); chk("ill1", ev(3'b010, 4'b1111, 2'b11, 1'b0, 1'b1));
        step(); chk("ill2", ev(3'b010, 4'b1111, 2'b11, 1'b0, 1'b1));
        bus.cmd_turn = 4'b1001;
        step(); chk("ill_clear", ev(3'b010, 4'b1001, 2'b11, 1'b0, 1'b0));
        bus.cmd_turn = 4'b0011;
        step(); chk("ill_nobrk", ev(3'b010, 4'b1111, 2'b11, 1'b0, 1'b1));
        bus.cmd_turn = 4'b1001;
        step(); chk("ill_back", ev(3'b010, 4'b1001, 2'b11, 1'b0, 1'b0));

        // same-code handover
        bus.req = 3'b011; bus.cmd_stop = 4'b1001;
        step(); chk("handover", ev(3'b001, 4'b1001, 2'b11, 1'b0, 1'b0));

        // reset mid-brake
        bus.cmd_stop = 4'b0110;
        step(); chk("rst_b1", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("rst_b2", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        reset = 1'b1;
        step(); chk("rst_mid", ev(3'b000, 4'b0000, 2'b00, 1'b0, 1'b0));
        reset = 1'b0; bus.req = 3'b100; bus.cmd_line = 4'b1001;
        step(); chk("rst_drive", ev(3'b100, 4'b1001, 2'b11, 1'b0, 1'b0));

        // winner code change mid-brake does not restart count
        bus.cmd_line = 4'b0110;
        step(); chk("nr_b1", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        bus.cmd_line = 4'b0101;
        step(); chk("nr_b2", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("nr_b3", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("nr_b4", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        step(); chk("nr_end", ev(3'b100, 4'b0101, 2'b11, 1'b0, 1'b0));

        // all requests drop mid-brake
        bus.cmd_line = 4'b1010;
        step(); chk("dr_b1", ev(3'b000, 4'b1111, 2'b11, 1'b1, 1'b0));
        bus.req = 3'b000;
        step(); chk("dr_idle", ev(3'b000, 4'b0000, 2'b00, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
